fifo_wr_arbiter: RTL and testbench

- Write-side controller for the dual-port FIFO RAM, in the write clock domain.
- Shares the single RAM write port between NREQ requesters using round-robin arbitration.
- Owns the write pointer (binary for RAM addressing, Gray for CDC export).
- Generates the registered wfull and walmost_full flags against the read pointer already synchronised into wclk.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_gray2bin.sv | 14 +
 rtl/fifo_wr_arbiter.sv | 96 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary pointer conversion and depth derivation.
// The conversions run on a 32-bit zero-extended value; callers truncate to pointer width.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done with doubling shifts.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary conversion of a synchronised pointer.
// Shared by the write- and read-side controllers.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(32'(gray)));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// FIFO write-side controller: round-robin sharing of the RAM write port,
// binary/Gray write pointer ownership, and registered full/almost-full flags.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NREQ       = 4,
  parameter int AFULL_TH   = 6
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  input  logic [ADDR_WIDTH:0]       wq2_rptr,
  output logic [NREQ-1:0]           grant,
  output logic                      wclken,
  output logic [ADDR_WIDTH-1:0]     waddr,
  output logic [DATAWIDTH-1:0]      wdata,
  output logic [ADDR_WIDTH:0]       wptr,
  output logic                      wfull,
  output logic                      walmost_full
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = $clog2(NREQ);
  localparam logic [LW-1:0] LAST_RST  = LW'(NREQ - 1);
  // Full means the write Gray pointer equals the read one with its top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] occ;
  logic [LW-1:0] last;
  logic [LW-1:0] win;
  logic [LW-1:0] idx;
  logic          found;

  fifo_gray2bin #(.W(PW)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  always_comb begin
    found = 1'b0;
    win   = last;
    idx   = last;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (!wrst_n || wfull) begin
      found = 1'b0;
    end
  end

  always_comb begin
    grant = '0;
    wdata = '0;
    if (found) begin
      grant[win] = 1'b1;
      wdata      = req_data[win*DATAWIDTH +: DATAWIDTH];
    end
  end

  assign wclken     = |grant;
  assign waddr      = wbin[ADDR_WIDTH-1:0];
  assign wbin_next  = wbin + PW'(wclken);
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));
  assign occ        = wbin_next - rbin;

  // Flags compare against the lagging synchronised read pointer, so they release late, never early.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      last         <= LAST_RST;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == (wq2_rptr ^ FULL_MASK));
      walmost_full <= (int'(occ) >= AFULL_TH);
      if (wclken) begin
        last <= win;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: occupancy-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int N  = 4;
  localparam int TH = 6;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [AW:0]     wq2_rptr;
  logic [N-1:0]    grant;
  logic            wclken;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [AW:0]     wptr;
  logic            wfull;
  logic            walmost_full;

  int tests = 0;
  int fails = 0;
  int rd    = 0;

  int m_wcnt  = 0;
  int m_last  = N - 1;
  bit m_full  = 1'b0;
  bit m_afull = 1'b0;

  logic [3:0] wseq [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
  logic [3:0] rseq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  fifo_wr_arbiter #(
    .DATAWIDTH  (DW),
    .ADDR_WIDTH (AW),
    .NREQ       (N),
    .AFULL_TH   (TH)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .req          (req),
    .req_data     (req_data),
    .wq2_rptr     (wq2_rptr),
    .grant        (grant),
    .wclken       (wclken),
    .waddr        (waddr),
    .wdata        (wdata),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full)
  );

  always #5 wclk = ~wclk;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner is the requesting index closest after the last winner, going round.
  function automatic int m_pick();
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    if (!wrst_n || m_full) return -1;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        d = (i - m_last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_wcnt  = 0;
      m_last  = N - 1;
      m_full  = 1'b0;
      m_afull = 1'b0;
    end else begin : upd
      int p;
      int occ;
      p = m_pick();
      if (p >= 0) begin
        m_wcnt = (m_wcnt + 1) % 16;
        m_last = p;
      end
      occ     = (m_wcnt - rd + 16) % 16;
      m_full  = (occ == 8);
      m_afull = (occ >= TH);
    end
  end

  always @(negedge wclk) begin : cmp
    int p;
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    p  = m_pick();
    eg = '0;
    ed = '0;
    if (p >= 0) begin
      eg = N'(1) << p;
      ed = req_data[p*DW +: DW];
    end
    chk("grant", grant, eg);
    chk("wclken", wclken, |eg);
    chk("waddr", waddr, m_wcnt % 8);
    chk("wdata", wdata, ed);
    chk("wptr", wptr, to_gray(m_wcnt));
    chk("wfull", wfull, m_full);
    chk("walmost_full", walmost_full, m_afull);
  end

  task automatic set_rd(input int v);
    rd       = v % 16;
    wq2_rptr = to_gray(rd);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    #1;
    wrst_n = 1'b0;
    req    = '0;
    set_rd(0);
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n   = 1'b0;
    req      = 4'b1111;
    req_data = 32'h44332211;
    set_rd(0);

    // Reset holds everything idle even with all requests up.
    @(negedge wclk);
    @(negedge wclk);
    #1;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_wclken", wclken, 1'b0);
    chk("rst_wptr", wptr, 4'd0);
    chk("rst_wfull", wfull, 1'b0);
    chk("rst_afull", walmost_full, 1'b0);
    wrst_n = 1'b1;
    #1;
    chk("first_grant", grant, 4'b0001);
    req = '0;

    // Fill with one requester until full.
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      req_data[23:16] = 8'(16 + k);
      #1;
      chk("fill_grant", grant, 4'b0100);
      chk("fill_waddr", waddr, k);
      chk("fill_wdata", wdata, 16 + k);
      @(posedge wclk);
      #1;
      chk("fill_wptr", wptr, wseq[k]);
    end
    chk("fill_full", wfull, 1'b1);
    chk("full_grant", grant, 4'b0000);
    chk("full_wclken", wclken, 1'b0);

    // Reader advances by one: full drops, one write lands, full again.
    req_data[23:16] = 8'h18;
    set_rd(1);
    @(posedge wclk);
    #1;
    chk("rel_wfull0", wfull, 1'b0);
    chk("rel_grant", grant, 4'b0100);
    chk("rel_waddr", waddr, 3'd0);
    chk("rel_wdata", wdata, 8'h18);
    @(posedge wclk);
    #1;
    chk("rel_wfull1", wfull, 1'b1);
    chk("rel_wptr", wptr, 4'b1101);
    req = '0;

    // Round robin with an instantly draining reader.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", grant, rseq[k]);
      @(posedge wclk);
      #1;
      set_rd(k + 1);
    end
    req = 4'b1101;
    #1;
    chk("rr_skip", grant, 4'b0100);
    req = '0;

    // Almost-full threshold and its release.
    do_reset();
    req = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      @(posedge wclk);
      #1;
      if (k == 5) chk("af_after5", walmost_full, 1'b0);
      if (k == 6) chk("af_after6", walmost_full, 1'b1);
    end
    req = '0;
    set_rd(1);
    @(posedge wclk);
    #1;
    chk("af_release", walmost_full, 1'b0);
    chk("af_nofull", wfull, 1'b0);

    // Pointer wrap with a following reader, then reset mid-cycle.
    do_reset();
    req = 4'b0010;
    for (int k = 1; k <= 16; k++) begin
      @(posedge wclk);
      #1;
      set_rd(k);
    end
    chk("wrap_wptr", wptr, 4'd0);
    chk("wrap_full", wfull, 1'b0);
    for (int k = 17; k <= 19; k++) begin
      @(posedge wclk);
      #1;
      set_rd(k);
    end
    chk("pre_rst_wptr", wptr, 4'd2);
    @(negedge wclk);
    #1;
    wrst_n = 1'b0;
    req    = 4'b1111;
    set_rd(0);
    #1;
    chk("mid_rst_wptr", wptr, 4'd0);
    chk("mid_rst_grant", grant, 4'b0000);
    #1;
    wrst_n = 1'b1;
    #1;
    chk("post_rst_grant", grant, 4'b0001);
    req = '0;

    @(negedge wclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
